cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one memory port between an instruction cache (I) and a data cache
//   (D). One requester owns the port for up to BURST_LEN consecutive beats.
//   Ties in IDLE go round-robin against the last owner.
//
// Ports
//   clk, reset              : clock, async active-low reset
//   i_/d_req, _wen          : per-cache request and write flag
//   i_/d_addr, _wdata       : per-cache address / write data (forwarded live)
//   i_/d_addr_ok, _data_ok  : per-cache handshakes (only the owner ever sees them)
//   i_/d_rdata              : read data (mirror of mem_rdata, qualified by data_ok)
//   mem_req/wen/addr/wdata  : shared memory request
//   mem_addr_ok/data_ok     : memory handshakes
//   mem_rdata               : memory read data
module cache_mem_arbiter #(
  parameter int BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_wen,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  mem_cmd_t i_cmd, d_cmd, sel_cmd;
  logic     own_req;
  logic     addr_hs, data_hs;
  logic [CW-1:0] beat_inc;

  assign i_cmd   = '{wen: i_wen, addr: i_addr, wdata: d_wdata_dummy_guard(i_wdata)};
  assign d_cmd   = '{wen: d_wen, addr: d_addr, wdata: d_wdata};

  // Command mux follows owner even outside ADDR; owner resets to I, so the
  // I-side inputs show through during reset. Only mem_req carries meaning.
  assign sel_cmd = (owner_q == OWN_D) ? d_cmd : i_cmd;
  assign own_req = (owner_q == OWN_D) ? d_req : i_req;

  assign mem_wen   = sel_cmd.wen;
  assign mem_addr  = sel_cmd.addr;
  assign mem_wdata = sel_cmd.wdata;
  assign mem_req   = (state_q == ADDR) && own_req;

  // Handshakes must pulse in the same cycle as the memory ok, so they are
  // decoded from registered state rather than registered themselves.
  assign addr_hs = (state_q == ADDR) && own_req && mem_addr_ok;
  assign data_hs = (state_q == DATA) && mem_data_ok;

  assign i_addr_ok = addr_hs && (owner_q == OWN_I);
  assign d_addr_ok = addr_hs && (owner_q == OWN_D);
  assign i_data_ok = data_hs && (owner_q == OWN_I);
  assign d_data_ok = data_hs && (owner_q == OWN_D);

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  assign beat_inc = beat_cnt_q + CW'(1);

  function automatic logic [31:0] d_wdata_dummy_guard(input logic [31:0] v);
    return v;
  endfunction

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          owner_d = ~last_owner_q;  // round-robin: the one that went last waits
          state_d = ADDR;
        end else if (d_req) begin
          owner_d = OWN_D;
          state_d = ADDR;
        end else if (i_req) begin
          owner_d = OWN_I;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (!own_req) begin
          // Owner withdrew before the address was accepted: release the port.
          state_d      = IDLE;
          last_owner_d = owner_q;
          beat_cnt_d   = '0;
        end else if (mem_addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (mem_data_ok) begin
          if (own_req && (beat_inc < BURST_MAX)) begin
            beat_cnt_d = beat_inc;
            state_d    = ADDR;
          end else begin
            state_d      = IDLE;
            last_owner_d = owner_q;
            beat_cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_wen, d_req, d_wen;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.BURST_LEN(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge; inputs are driven there
  // and outputs are sampled 1 unit later, well away from either clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b0;
    i_req = 0; i_wen = 0; d_req = 0; d_wen = 0;
    i_addr = 32'hAAAA_0000; i_wdata = 32'h0; d_addr = 32'hBBBB_0000; d_wdata = 32'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;

    // Reset state: port idle, I-side inputs visible on the memory bus.
    tick(); i_req = 1; d_req = 1; mem_addr_ok = 1; mem_data_ok = 1; settle();
    chk("rst_mem_req",   32'(mem_req), 0);
    chk("rst_mem_addr",  mem_addr, 32'hAAAA_0000);
    chk("rst_oks",       32'({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}), 0);
    i_req = 0; d_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    tick(); reset = 1'b1;

    // Tie after reset: D wins first, then I.
    tick(); i_req = 1; d_req = 1; settle();
    chk("tie_idle_mem_req", 32'(mem_req), 0);
    tick(); mem_addr_ok = 1; settle();
    chk("tie_d_granted_addr", mem_addr, 32'hBBBB_0000);
    chk("tie_d_mem_req",      32'(mem_req), 1);
    chk("tie_d_addr_ok",      32'({i_addr_ok, d_addr_ok}), 32'b01);
    tick(); mem_addr_ok = 0; d_req = 0; mem_data_ok = 1; mem_rdata = 32'h0BAD_F00D; settle();
    chk("tie_d_data_ok",      32'({i_data_ok, d_data_ok}), 32'b01);
    tick(); mem_data_ok = 0; settle();
    chk("tie_idle2_mem_req",  32'(mem_req), 0);
    // Next grant goes to I; exercise a write and live forwarding in ADDR.
    tick(); i_wen = 1; i_wdata = 32'h1234_5678; settle();
    chk("tie_i_granted_addr", mem_addr, 32'hAAAA_0000);
    chk("wr_mem_wen",         32'(mem_wen), 1);
    chk("wr_mem_wdata",       mem_wdata, 32'h1234_5678);
    chk("wr_no_addr_ok_yet",  32'(i_addr_ok), 0);
    tick(); i_addr = 32'hAAAA_0100; mem_addr_ok = 1; settle();
    chk("wr_addr_forwarded",  mem_addr, 32'hAAAA_0100);
    chk("wr_i_addr_ok",       32'({i_addr_ok, d_addr_ok}), 32'b10);
    tick(); i_req = 0; settle();
    // mem_addr_ok still high in DATA must be ignored.
    chk("wr_data_mem_req",    32'(mem_req), 0);
    chk("wr_data_ignore_aok", 32'(i_addr_ok), 0);
    chk("wr_data_wait",       32'(i_data_ok), 0);
    tick(); mem_addr_ok = 0; mem_data_ok = 1; settle();
    chk("wr_i_data_ok",       32'({i_data_ok, d_data_ok}), 32'b10);
    tick(); i_wen = 0; settle();
    // Back in IDLE with a stray mem_data_ok: ignored.
    chk("idle_ignore_dok",    32'({i_data_ok, d_data_ok}), 0);
    mem_data_ok = 0;

    // Single D read.
    d_addr = 32'h1000_0040; d_req = 1;
    tick(); mem_addr_ok = 1; settle();
    chk("rd_mem_addr",        mem_addr, 32'h1000_0040);
    chk("rd_mem_wen",         32'(mem_wen), 0);
    chk("rd_d_addr_ok",       32'({i_addr_ok, d_addr_ok}), 32'b01);
    tick(); mem_addr_ok = 0; d_req = 0; mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF; settle();
    chk("rd_d_data_ok",       32'({i_data_ok, d_data_ok}), 32'b01);
    chk("rd_d_rdata",         d_rdata, 32'hDEAD_BEEF);
    chk("rd_i_rdata",         i_rdata, 32'hDEAD_BEEF);
    tick(); mem_data_ok = 0; settle();
    chk("rd_idle_mem_req",    32'(mem_req), 0);

    // Abandon: D drops request in ADDR, pending I is served next.
    d_req = 1;
    tick(); i_req = 1; d_req = 0; settle();
    chk("ab_mem_req",         32'(mem_req), 0);
    chk("ab_no_oks",          32'({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}), 0);
    tick(); settle();
    chk("ab_idle",            32'(mem_req), 0);
    tick(); mem_addr_ok = 1; settle();
    chk("ab_i_granted",       mem_addr, 32'hAAAA_0100);
    chk("ab_i_addr_ok",       32'({i_addr_ok, d_addr_ok}), 32'b10);
    tick(); mem_addr_ok = 0; i_req = 0; mem_data_ok = 1; settle();
    chk("ab_i_data_ok",       32'({i_data_ok, d_data_ok}), 32'b10);
    tick(); mem_data_ok = 0;

    // Burst cap: D held with I pending -> 8 D beats, then I, then D again.
    d_req = 1;
    tick(); i_req = 1;
    for (int b = 0; b < 8; b++) begin
      mem_addr_ok = 1; settle();
      chk($sformatf("bu_d_addr_ok%0d", b), 32'({mem_req, i_addr_ok, d_addr_ok}), 32'b101);
      tick(); mem_addr_ok = 0; mem_data_ok = 1; settle();
      chk($sformatf("bu_d_data_ok%0d", b), 32'({i_data_ok, d_data_ok}), 32'b01);
      tick(); mem_data_ok = 0;
    end
    settle();
    chk("bu_cap_idle",        32'(mem_req), 0);
    tick(); mem_addr_ok = 1; settle();
    chk("bu_i_granted",       mem_addr, 32'hAAAA_0100);
    chk("bu_i_addr_ok",       32'({i_addr_ok, d_addr_ok}), 32'b10);
    tick(); mem_addr_ok = 0; i_req = 0; mem_data_ok = 1; settle();
    chk("bu_i_data_ok",       32'({i_data_ok, d_data_ok}), 32'b10);
    tick(); mem_data_ok = 0; settle();
    chk("bu_idle2",           32'(mem_req), 0);
    tick(); settle();
    chk("bu_d_resume",        32'({mem_req, mem_addr}), {1'b1, 32'h1000_0040});

    // Reset while D awaits data: abandon, late data_ok produces nothing.
    mem_addr_ok = 1;
    tick(); mem_addr_ok = 0; settle();
    chk("rd_wait_data",       32'(d_data_ok), 0);
    reset = 1'b0; mem_data_ok = 1; settle();
    chk("rstd_mem_req",       32'(mem_req), 0);
    chk("rstd_no_data_ok",    32'({i_data_ok, d_data_ok}), 0);
    chk("rstd_mem_addr_i",    mem_addr, 32'hAAAA_0100);
    tick(); reset = 1'b1; settle();
    chk("rstd_late_dok",      32'({i_data_ok, d_data_ok}), 0);
    mem_data_ok = 0;
    tick(); settle();
    chk("rstd_restart",       32'({mem_req, mem_addr}), {1'b1, 32'h1000_0040});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
